adc128s_spi_model: RTL and testbench
====================================

Name: adc128s_spi_model

Overview:
- Behavioural/synthesizable model of the 8-channel, 12-bit ADC128S022 A2D converter as used on the DE0 board.
- It sits on the A2D SPI bus of the Segway top-level bench and answers the Segway A2D SPI master with load-cell-left, load-cell-right and battery readings.
- It is an SPI slave: each 16-bit frame carries the next channel address in and returns the conversion of the channel addressed in the previous frame.

Parameters:
- LFT_VAL, 12'h3C0, value returned for channel 0 (left load cell)
- RGHT_VAL, 12'h3C0, value returned for channel 4 (right load cell)
- BATT_VAL, 12'hC00, value returned for channel 5 (battery)

Ports:
- clk  input  1  system clock; all logic runs on its rising edge
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  SPI slave select, active low; frame boundary
- SCLK  input  1  SPI serial clock from master, idle high
- MOSI  input  1  master-out data, sampled on SCLK rise
- MISO  output  1  slave-out data, changed on SCLK fall; high-Z while SS_n high

Behaviour:
- Clocking: one clock (clk). Reset is asynchronous, active-low (rst_n). SCLK and SS_n are treated as asynchronous inputs.
- Synchronizers: SCLK and SS_n each pass through 3 flops.
  - sclk_rise = s2 & ~s3; sclk_fall = ~s2 & s3.
  - ss_fall and ss_rise are decoded the same way.
  - MOSI is sampled on the flop stage aligned with s2.
- SPI mode: CPOL=1/CPHA=1. SCLK half-period must be at least 4 clk cycles; the Segway master runs at clk/32.
- Frame: 16 bits, MSB first.
  - Received word bits [13:11] give the channel address for the next frame; all other received bits are ignored.
- Transmit word is {4'b0000, value[11:0]}, where value is that of the channel latched at the end of the previous complete frame.
- Channel map:
  - ch0 -> LFT_VAL
  - ch4 -> RGHT_VAL
  - ch5 -> BATT_VAL
  - any other channel n -> {1'b0, n[2:0], 8'h00}, e.g. ch2 -> 12'h200
- On ss_fall:
  - tx shift register loads the transmit word;
  - bit counter clears;
  - MISO presents bit 15 within 3 clk of the SS_n falling edge.
- On sclk_fall (SS_n low): tx register shifts left, filling with 0, so MISO presents the next bit.
  - The first SCLK fall of a frame does not shift; bit 15 is already presented. Track this with a first-edge flag.
- On sclk_rise (SS_n low):
  - MOSI shifts into the rx register;
  - bit counter increments, saturating at 16;
  - rises beyond 16 are ignored.
- On ss_rise:
  - if the bit counter equals 16, latch rx[13:11] into the channel register;
  - otherwise the frame is aborted and the channel register is unchanged.
- MISO = tx[15] when synchronized SS_n is low, 1'bz otherwise.
- Reset values:
  - channel register = 0; tx = 16'h0000; rx = 0; bit counter = 0;
  - synchronizer flops: SCLK and SS_n stages reset to 1.
  - Consequence: the first frame after reset returns 16'h0000 regardless of the command.
- Reset mid-frame: all state returns to reset values. The partial frame is discarded, and the next frame after SS_n re-asserts returns 16'h0000.
- Simultaneous ss_rise and sclk_rise cannot occur with a legal master. If they do, ss_rise wins and the in-flight bit is dropped.

Decomposition:
- Package adc128s_pkg holds:
  - channel constants CH_LFT=3'd0, CH_RGHT=3'd4, CH_BATT=3'd5;
  - FRAME_BITS=16;
  - the function channel_value(ch, lft, rght, batt).
- One sub-module is natural: spi_edge_sync. It provides the 3-flop synchronizer with rise/fall pulse outputs and is instantiated for SCLK and SS_n.

Test Plan:
- After reset, frame with command 16'h0000 returns 16'h0000; the second frame (command 16'h2000, ch4) returns 16'h03C0 (LFT_VAL).
- Third frame (command 16'h2800, ch5) returns 16'h03C0 (RGHT_VAL); fourth frame returns 16'h0C00 (BATT_VAL).
- Command 16'h1000 (ch2) followed by any frame returns 16'h0200. MISO is high-Z whenever SS_n is high.
- Aborted frame: latch ch5, then send only 8 SCLKs of a ch0 command and raise SS_n. The next full frame still returns 16'h0C00.
- Reset asserted mid-frame: the frame is discarded, and the next frame returns 16'h0000 with the channel register at 0.
- Override parameters LFT_VAL=12'h123, BATT_VAL=12'hABC: ch0 readback is 16'h0123 and ch5 readback is 16'h0ABC. Timing is checked with SCLK = clk/32: MISO is stable for at least 12 clk before each SCLK rise.

Source files
------------

// File: rtl/adc128s_pkg.sv
// Shared constants and channel-to-value mapping for the ADC128S022 SPI model.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adc128s_pkg;

    localparam logic [2:0] CH_LFT  = 3'd0;
    localparam logic [2:0] CH_RGHT = 3'd4;
    localparam logic [2:0] CH_BATT = 3'd5;

    localparam int FRAME_BITS = 16;

    // Conversion result for a channel. Channels without a sensor attached
    // return their own number in the top nibble so they are recognisable.
    function automatic logic [11:0] channel_value(
        input logic [2:0]  ch,
        input logic [11:0] lft,
        input logic [11:0] rght,
        input logic [11:0] batt
    );
        logic [11:0] val;
        case (ch)
            CH_LFT:  val = lft;
            CH_RGHT: val = rght;
            CH_BATT: val = batt;
            default: val = {1'b0, ch, 8'h00};
        endcase
        return val;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Three-flop synchronizer for an asynchronous SPI control line with edge pulses.
// Latency: rise/fall pulse one clk wide, two clk after the input edge.
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   din        : asynchronous input (idles high, so stages reset to 1)
//   rise, fall : single-cycle pulses on synchronized rising/falling edges
module spi_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    // stage[0] = s1 (metastability catcher), stage[1] = s2, stage[2] = s3
    logic [2:0] stage;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= 3'b111;
        end else begin
            stage <= {stage[1:0], din};
        end
    end

    assign rise =  stage[1] & ~stage[2];
    assign fall = ~stage[1] &  stage[2];

endmodule

// File: rtl/adc128s_spi_model.sv
// ADC128S022 SPI slave model: returns the channel addressed in the previous frame.
// Latency: MISO valid 3 clk after SS_n falls; each bit updates 3 clk after SCLK falls.
// Backpressure: none; master must keep SCLK half-period >= 4 clk.
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   SS_n       : slave select, active low, frames a 16-bit transfer
//   SCLK       : serial clock (CPOL=1/CPHA=1), idles high
//   MOSI       : command bits, sampled on SCLK rise; bits [13:11] select next channel
//   MISO       : response bits, changed on SCLK fall; high-Z while deselected
module adc128s_spi_model
    import adc128s_pkg::*;
#(
    parameter logic [11:0] LFT_VAL  = 12'h3C0,
    parameter logic [11:0] RGHT_VAL = 12'h3C0,
    parameter logic [11:0] BATT_VAL = 12'hC00
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic SCLK,
    input  logic MOSI,
    output logic MISO
);

    localparam logic [4:0] FULL_CNT = 5'(FRAME_BITS);

    logic        sclk_rise;
    logic        sclk_fall;
    logic        ss_rise;
    logic        ss_fall;

    logic [1:0]  mosi_sync;
    logic        ss_act;
    logic        first_edge;
    logic        ch_vld;
    logic [2:0]  channel;
    logic [15:0] tx;
    logic [15:0] rx;
    logic [4:0]  bit_cnt;

    spi_edge_sync u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SCLK),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_edge_sync u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SS_n),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // Two stages so the sampled MOSI lines up with the SCLK s2 stage that
    // produces sclk_rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync <= 2'b00;
        end else begin
            mosi_sync <= {mosi_sync[0], MOSI};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_act     <= 1'b0;
            first_edge <= 1'b0;
            ch_vld     <= 1'b0;
            channel    <= 3'd0;
            tx         <= 16'h0000;
            rx         <= 16'h0000;
            bit_cnt    <= 5'd0;
        end else if (ss_rise) begin
            // Frame end wins over any coincident SCLK edge; the in-flight bit
            // is dropped. Only a complete frame updates the channel.
            ss_act <= 1'b0;
            if (bit_cnt == FULL_CNT) begin
                channel <= rx[13:11];
                ch_vld  <= 1'b1;
            end
        end else if (ss_fall) begin
            ss_act     <= 1'b1;
            first_edge <= 1'b1;
            bit_cnt    <= 5'd0;
            // Until one full frame has been received since reset there is no
            // addressed channel, so the response is all zeros.
            tx <= ch_vld ? {4'b0000, channel_value(channel, LFT_VAL, RGHT_VAL, BATT_VAL)}
                         : 16'h0000;
        end else if (ss_act) begin
            if (sclk_fall) begin
                // Bit 15 is already on MISO from the frame start, so the
                // first fall of a frame must not shift it away.
                if (first_edge) begin
                    first_edge <= 1'b0;
                end else begin
                    tx <= {tx[14:0], 1'b0};
                end
            end
            if (sclk_rise && (bit_cnt != FULL_CNT)) begin
                rx      <= {rx[14:0], mosi_sync[1]};
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    assign MISO = ss_act ? tx[15] : 1'bz;

endmodule

// File: tb/tb_adc128s_spi_model.sv
// Randomized self-checking bench for adc128s_spi_model with a frame-level model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_adc128s_spi_model;

    logic       clk;
    logic       rst_n;
    logic       sclk;
    logic       mosi;
    logic [1:0] ss_n;
    wire  [1:0] miso;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: per-DUT "last completed channel" and whether any
    // complete frame has been seen since reset.
    int          m_ch  [2];
    bit          m_vld [2];
    logic [11:0] m_lft [2];
    logic [11:0] m_rght[2];
    logic [11:0] m_batt[2];

    adc128s_spi_model u_dut_def (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (ss_n[0]),
        .SCLK  (sclk),
        .MOSI  (mosi),
        .MISO  (miso[0])
    );

    adc128s_spi_model #(
        .LFT_VAL  (12'h123),
        .BATT_VAL (12'hABC)
    ) u_dut_ovr (
        .clk   (clk),
        .rst_n (rst_n),
        .SS_n  (ss_n[1]),
        .SCLK  (sclk),
        .MOSI  (mosi),
        .MISO  (miso[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] model_word(input int d);
        logic [15:0] w;
        if (!m_vld[d])          w = 16'h0000;
        else if (m_ch[d] == 0)  w = {4'h0, m_lft[d]};
        else if (m_ch[d] == 4)  w = {4'h0, m_rght[d]};
        else if (m_ch[d] == 5)  w = {4'h0, m_batt[d]};
        else                    w = 16'(m_ch[d]) << 8;
        return w;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ch[d]  = 0;
            m_vld[d] = 1'b0;
        end
    endtask

    // One SPI transaction at SCLK = clk/32. Returns the first min(nbits,16)
    // response bits and whether MISO held steady over the last 12 clk of every
    // SCLK-low phase. With rst_mid set, reset is pulsed while SS_n is still low.
    task automatic spi_frame(input int d, input logic [15:0] cmd, input int nbits,
                             input bit rst_mid, output logic [15:0] resp,
                             output bit stable);
        logic ref_bit;
        resp   = 16'h0000;
        stable = 1'b1;
        ref_bit = 1'b0;
        @(negedge clk);
        ss_n[d] = 1'b0;
        repeat (8) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            sclk = 1'b0;
            mosi = (b < 16) ? cmd[15 - b] : 1'b0;
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                if (i == 5) ref_bit = miso[d];
                else if (i > 5 && miso[d] !== ref_bit) stable = 1'b0;
            end
            if (b < 16) resp = {resp[14:0], miso[d]};
            sclk = 1'b1;
            repeat (16) @(negedge clk);
        end
        if (rst_mid) begin
            rst_n = 1'b0;
            repeat (3) @(negedge clk);
            ss_n[d] = 1'b1;
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
        end else begin
            ss_n[d] = 1'b1;
        end
        repeat (8) @(negedge clk);
    endtask

    // Run a frame, compare against the model, then advance the model.
    task automatic run_frame(input int d, input logic [15:0] cmd, input int nbits,
                             input string tag, output logic [15:0] resp);
        logic [15:0] exp;
        bit          stable;
        exp = model_word(d);
        spi_frame(d, cmd, nbits, 1'b0, resp, stable);
        if (nbits >= 16) chk(tag, resp, exp);
        else             chk(tag, resp, exp >> (16 - nbits));
        chk({tag, "_miso_stable"}, {15'd0, stable}, 16'd1);
        if (nbits >= 16) begin
            m_ch[d]  = int'(cmd[13:11]);
            m_vld[d] = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] resp;
        bit          stable;
        int          d;
        int          nb;
        logic [15:0] cmd;

        m_lft[0] = 12'h3C0; m_rght[0] = 12'h3C0; m_batt[0] = 12'hC00;
        m_lft[1] = 12'h123; m_rght[1] = 12'h3C0; m_batt[1] = 12'hABC;
        model_reset();

        rst_n = 1'b0;
        sclk  = 1'b1;
        mosi  = 1'b0;
        ss_n  = 2'b11;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        chk("reset_channel", {13'd0, u_dut_def.channel}, 16'h0000);
        chk("reset_tx", u_dut_def.tx, 16'h0000);
        chk("reset_bit_cnt", {11'd0, u_dut_def.bit_cnt}, 16'h0000);

        // Directed sequence on the default-parameter instance.
        run_frame(0, 16'h0000, 16, "first_frame", resp);
        chk("first_frame_lit", resp, 16'h0000);
        run_frame(0, 16'h2000, 16, "ch0_read", resp);
        chk("ch0_read_lit", resp, 16'h03C0);
        run_frame(0, 16'h2800, 16, "ch4_read", resp);
        chk("ch4_read_lit", resp, 16'h03C0);
        run_frame(0, 16'h1000, 16, "ch5_read", resp);
        chk("ch5_read_lit", resp, 16'h0C00);
        run_frame(0, 16'h2800, 16, "ch2_read", resp);
        chk("ch2_read_lit", resp, 16'h0200);

        // Aborted frame must leave channel 5 latched.
        run_frame(0, 16'h0000, 8, "abort", resp);
        run_frame(0, 16'h0000, 16, "after_abort", resp);
        chk("after_abort_lit", resp, 16'h0C00);

        // Overridden-parameter instance.
        run_frame(1, 16'h0000, 16, "ovr_first", resp);
        run_frame(1, 16'h2800, 16, "ovr_ch0", resp);
        chk("ovr_ch0_lit", resp, 16'h0123);
        run_frame(1, 16'h0000, 16, "ovr_ch5", resp);
        chk("ovr_ch5_lit", resp, 16'h0ABC);

        // Random commands, occasional short or over-long frames.
        for (int k = 0; k < 24; k++) begin
            d   = int'($urandom_range(0, 1));
            cmd = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       nb = int'($urandom_range(1, 15));
                1:       nb = 17;
                default: nb = 16;
            endcase
            run_frame(d, cmd, nb, $sformatf("rand%0d_d%0d_n%0d", k, d, nb), resp);
        end

        // Reset in the middle of a frame discards everything.
        spi_frame(0, 16'h2800, 8, 1'b1, resp, stable);
        model_reset();
        chk("midrst_channel", {13'd0, u_dut_def.channel}, 16'h0000);
        run_frame(0, 16'h0000, 16, "midrst_next", resp);
        chk("midrst_next_lit", resp, 16'h0000);
        run_frame(0, 16'h0000, 16, "midrst_ch0", resp);
        chk("midrst_ch0_lit", resp, 16'h03C0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
